// File: rtl/tick_gen_pkg.sv
// Shared types and default widths for the tick generator.
// Optional burst mode is enabled by defining TICK_GEN_BURST_EN.
package tick_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int N_DEF = 8;
  localparam int B_DEF = 8;

endpackage

// File: rtl/tick_divider.sv
// N-bit divide counter: clear, hold, count up and wrap at limit.
// wrap flags the advancing cycle in which the count equals limit.
module tick_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         advance,
  input  logic [N-1:0] limit,
  output logic         wrap
);

  logic [N-1:0] cnt;

  assign wrap = advance && (cnt == limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_gen_prescaler.sv
// Start/stop/pause tick prescaler driving a downstream counter enable.
// Define TICK_GEN_BURST_EN to add burst_len/done and a burst counter.
module tick_gen_prescaler
  import tick_gen_pkg::*;
#(
  parameter int N = N_DEF
`ifdef TICK_GEN_BURST_EN
  ,
  parameter int B = B_DEF
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic [N-1:0] div_val,
`ifdef TICK_GEN_BURST_EN
  input  logic [B-1:0] burst_len,
`endif
  output logic         count_enb,
  output logic         busy
`ifdef TICK_GEN_BURST_EN
  ,
  output logic         done
`endif
);

  state_t       state;
  logic [N-1:0] div_q;
  logic         advance;
  logic         wrap;

`ifdef TICK_GEN_BURST_EN
  logic [B-1:0] len_q;
  logic [B-1:0] burst_cnt;
`endif

  // The divider only moves on edges where the block keeps running.
  assign advance = (state != IDLE) && !stop && !pause;

  tick_divider #(
    .N (N)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .advance (advance),
    .limit   (div_q),
    .wrap    (wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div_q     <= '0;
      count_enb <= 1'b0;
      busy      <= 1'b0;
`ifdef TICK_GEN_BURST_EN
      len_q     <= '0;
      burst_cnt <= '0;
      done      <= 1'b0;
`endif
    end else begin
      count_enb <= 1'b0;
`ifdef TICK_GEN_BURST_EN
      done      <= 1'b0;
`endif
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= RUN;
              busy  <= 1'b1;
              div_q <= div_val;
`ifdef TICK_GEN_BURST_EN
              len_q     <= burst_len;
              burst_cnt <= '0;
`endif
            end
          end
          RUN, PAUSE: begin
            if (pause) begin
              state <= PAUSE;
            end else begin
              state <= RUN;
              if (wrap) begin
                count_enb <= 1'b1;
`ifdef TICK_GEN_BURST_EN
                if (len_q != '0) begin
                  // Last tick of the burst leaves RUN on its own edge.
                  if (burst_cnt == len_q - B'(1)) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    burst_cnt <= '0;
                  end else begin
                    burst_cnt <= burst_cnt + 1'b1;
                  end
                end
`endif
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_gen_prescaler.sv
// Scoreboard bench: expected tick edges queued, monitor pops on count_enb.
// Burst cases are exercised when TICK_GEN_BURST_EN is defined.
module tb_tick_gen_prescaler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] div_val = 8'd0;
  logic       count_enb;
  logic       busy;
`ifdef TICK_GEN_BURST_EN
  logic [7:0] burst_len = 8'd0;
  logic       done;
`endif

  int cyc = 0;
  int q[$];
  int pass_n = 0;
  int total_n = 0;
  int s;

  tick_gen_prescaler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .div_val   (div_val),
`ifdef TICK_GEN_BURST_EN
    .burst_len (burst_len),
    .done      (done),
`endif
    .count_enb (count_enb),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every tick must match the next queued edge number.
  always @(negedge clk) begin
    if (count_enb !== 1'b0) begin
      if (q.size() == 0) begin
        total_n++;
        $display("FAIL unexpected_tick: got tick at edge %0d expected none",
                 cyc);
      end else begin
        chk("tick_edge", cyc, q.pop_front());
      end
    end
  end

  task automatic wait_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic start_run(input logic [7:0] d, output int se);
    div_val = d;
    start = 1'b1;
    se = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stop_now();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count_enb", count_enb, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);

    // div 3: ticks every 4; start and div_val changes while running ignored
    start_run(8'd3, s);
    q.push_back(s + 4);
    q.push_back(s + 8);
    q.push_back(s + 12);
    chk("run_busy", busy, 1);
    div_val = 8'd0;
    wait_edge(s + 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_edge(s + 13);
    stop_now();
    chk("stop_busy", busy, 0);
    repeat (4) @(negedge clk);

    // div 0: tick every cycle, stop clears next cycle
    start_run(8'd0, s);
    for (int i = 1; i <= 5; i++) q.push_back(s + i);
    wait_edge(s + 5);
    stop_now();
    chk("stop0_enb", count_enb, 0);
    chk("stop0_busy", busy, 0);
    repeat (3) @(negedge clk);

    // div 4 with 10-cycle pause mid-period
    start_run(8'd4, s);
    q.push_back(s + 5);
    q.push_back(s + 20);
    q.push_back(s + 25);
    wait_edge(s + 6);
    pause = 1'b1;
    wait_edge(s + 10);
    chk("pause_busy", busy, 1);
    chk("pause_enb", count_enb, 0);
    wait_edge(s + 16);
    pause = 1'b0;
    wait_edge(s + 25);
    stop_now();
    repeat (3) @(negedge clk);

    // start and stop on the same edge
    div_val = 8'd1;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_enb", count_enb, 0);
    repeat (6) @(negedge clk);

    // full-scale divider: period 256
    start_run(8'd255, s);
    q.push_back(s + 256);
    q.push_back(s + 512);
    wait_edge(s + 513);
    stop_now();
    repeat (3) @(negedge clk);

    // async reset while a tick is high
    start_run(8'd7, s);
    q.push_back(s + 8);
    q.push_back(s + 16);
    wait_edge(s + 16);
    chk("pre_rst_enb", count_enb, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_enb", count_enb, 0);
    chk("async_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy, 0);

`ifdef TICK_GEN_BURST_EN
    burst_len = 8'd3;
    start_run(8'd1, s);
    q.push_back(s + 2);
    q.push_back(s + 4);
    q.push_back(s + 6);
    wait_edge(s + 5);
    chk("burst_mid_done", done, 0);
    wait_edge(s + 6);
    chk("burst_done", done, 1);
    chk("burst_busy", busy, 0);
    @(negedge clk);
    chk("burst_done_low", done, 0);
    repeat (6) @(negedge clk);

    burst_len = 8'd5;
    start_run(8'd1, s);
    q.push_back(s + 2);
    wait_edge(s + 2);
    stop_now();
    chk("burst_stop_done", done, 0);
    @(negedge clk);
    chk("burst_stop_done2", done, 0);
    repeat (4) @(negedge clk);
`endif

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
